// File: rtl/fmr_pkg.sv
// fmr_pkg: definitions shared by the 5MR fault-management controller.
//   - fmr_state_t : operating mode encoding (NORMAL / DEGRADED / FAILED)
//   - NUM_REPLICAS: number of redundant replicas feeding the voter
//   - popcount5   : number of set bits in a replica-wide vector
package fmr_pkg;

    localparam int NUM_REPLICAS = 5;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FAILED   = 2'd2
    } fmr_state_t;

    function automatic logic [2:0] popcount5(input logic [NUM_REPLICAS-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_REPLICAS; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/fmr_vote_manager_if.sv
// fmr_vote_manager_if: sample / status bundle of the 5MR vote manager.
//   X, X_valid  : replica outputs and their sample strobe
//   clr         : repair pulse (unmask all, zero counters)
//   Z, Z_valid  : registered majority vote and its update strobe
//   tie         : even split of an even active set on the voted sample
//   mask        : 1 = replica excluded from voting
//   state       : operating mode (fmr_pkg::fmr_state_t encoding)
//   fault_irq   : one-cycle pulse when any replica becomes masked
// master = sample source / supervisor, slave = vote manager.
interface fmr_vote_manager_if;
    import fmr_pkg::*;

    logic [NUM_REPLICAS-1:0] X;
    logic                    X_valid;
    logic                    clr;
    logic                    Z;
    logic                    Z_valid;
    logic                    tie;
    logic [NUM_REPLICAS-1:0] mask;
    logic [1:0]              state;
    logic                    fault_irq;

    modport master (
        output X, X_valid, clr,
        input  Z, Z_valid, tie, mask, state, fault_irq
    );

    modport slave (
        input  X, X_valid, clr,
        output Z, Z_valid, tie, mask, state, fault_irq
    );

endinterface

// File: rtl/fmr_disagree_ctr.sv
// fmr_disagree_ctr: per-replica saturating leaky disagreement counter.
//   clk, rst  : clock, asynchronous active-high reset
//   step      : apply one update this cycle (otherwise the count is frozen)
//   up        : 1 = replica disagreed (count up), 0 = agreed (count down)
//   clr       : zero the counter (wins over step)
//   hit_next  : combinational, value the threshold flag takes on this edge
//   at_thresh : registered, count >= THRESH
module fmr_disagree_ctr #(
    parameter int CW     = 4,
    parameter int THRESH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic up,
    input  logic clr,
    output logic hit_next,
    output logic at_thresh
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] THR     = CW'(THRESH);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          at_thresh_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (step) begin
            if (up) begin
                if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CW'(1);
            end else begin
                if (cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
            end
        end
    end

    // Exposed so the parent can see the post-update mask on the same edge.
    assign hit_next = (cnt_next >= THR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= '0;
            at_thresh_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            at_thresh_reg <= hit_next;
        end
    end

    assign at_thresh = at_thresh_reg;

endmodule

// File: rtl/fmr_vote_manager.sv
// fmr_vote_manager: majority voter and fault manager for a 5MR datapath.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fmr_vote_manager_if.slave (samples in, vote/status out)
// Each accepted sample is voted over the unmasked replicas, every active
// replica's disagreement counter is stepped against the new majority, and
// replicas whose counter reaches THRESH are masked. The mode walks
// NORMAL -> DEGRADED -> FAILED as replicas drop out; only clr recovers.
module fmr_vote_manager
    import fmr_pkg::*;
#(
    parameter int CW     = 4,
    parameter int THRESH = 8
) (
    input  logic                clk,
    input  logic                rst,
    fmr_vote_manager_if.slave   bus
);

    logic [NUM_REPLICAS-1:0] mask_now;
    logic [NUM_REPLICAS-1:0] mask_next;
    logic [NUM_REPLICAS-1:0] active;
    logic [NUM_REPLICAS-1:0] step;
    logic [NUM_REPLICAS-1:0] up;
    logic [2:0]              n_act;
    logic [2:0]              n_next;
    logic [2:0]              ones;
    logic [3:0]              ones2;
    logic [3:0]              n_cmp;
    logic                    sample;
    logic                    is_tie;
    logic                    maj;

    fmr_state_t state_reg;
    fmr_state_t state_next;
    logic       z_reg;
    logic       z_valid_reg;
    logic       tie_reg;
    logic       irq_reg;

    assign active = ~mask_now;
    assign n_act  = popcount5(active);
    assign ones   = popcount5(bus.X & active);
    assign ones2  = {ones, 1'b0};
    assign n_cmp  = {1'b0, n_act};

    // clr drops the sample; FAILED ignores samples entirely.
    assign sample = bus.X_valid && !bus.clr && (state_reg != ST_FAILED);
    assign is_tie = (ones2 == n_cmp);

    // A tie keeps the previous vote.
    always_comb begin
        maj = z_reg;
        if (ones2 > n_cmp)      maj = 1'b1;
        else if (ones2 < n_cmp) maj = 1'b0;
    end

    // On a tie there is no reference value, so no counter moves.
    assign step = {NUM_REPLICAS{sample && !is_tie}} & active;
    assign up   = bus.X ^ {NUM_REPLICAS{maj}};

    // The registered threshold flags are the mask: a masked counter is
    // frozen at or above THRESH, and clr zeroes it together with the flag.
    generate
        for (genvar gi = 0; gi < NUM_REPLICAS; gi++) begin : g_ctr
            fmr_disagree_ctr #(
                .CW     (CW),
                .THRESH (THRESH)
            ) u_ctr (
                .clk       (clk),
                .rst       (rst),
                .step      (step[gi]),
                .up        (up[gi]),
                .clr       (bus.clr),
                .hit_next  (mask_next[gi]),
                .at_thresh (mask_now[gi])
            );
        end
    endgenerate

    assign n_next = popcount5(~mask_next);

    // Mode follows the post-update active count; FAILED only leaves on clr.
    always_comb begin
        state_next = state_reg;
        if (bus.clr) begin
            state_next = ST_NORMAL;
        end else if (state_reg != ST_FAILED) begin
            if (n_next < 3'd3)      state_next = ST_FAILED;
            else if (n_next < 3'd5) state_next = ST_DEGRADED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_NORMAL;
            z_reg       <= 1'b0;
            z_valid_reg <= 1'b0;
            tie_reg     <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            if (sample) z_reg <= maj;
            z_valid_reg <= sample;
            tie_reg     <= sample && is_tie;
            irq_reg     <= |(mask_next & ~mask_now);
        end
    end

    assign bus.Z         = z_reg;
    assign bus.Z_valid   = z_valid_reg;
    assign bus.tie       = tie_reg;
    assign bus.mask      = mask_now;
    assign bus.state     = state_reg;
    assign bus.fault_irq = irq_reg;

endmodule
